// File: rtl/powerup_pkg.sv
// Shared types and constants for the powerup sprite scheduler: sprite geometry,
// the queued loader write entry and the drain FSM state encoding.
package powerup_pkg;

  localparam int SPRITE_DIM    = 15;
  localparam int SPRITE_PIXELS = 225;
  localparam int ADDR_W        = 8;

  typedef logic [1:0] pixel_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    pixel_t            data;
  } wr_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  // Writes aimed past the last sprite pixel are popped but never committed.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(SPRITE_PIXELS);
  endfunction

endpackage

// File: rtl/powerup_wr_fifo.sv
// Synchronous FIFO holding loader writes until vertical blank lets them commit.
// Push is ignored when full and pop is ignored when empty.
module powerup_wr_fifo
  import powerup_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push,
  input  wr_entry_t                push_data,
  input  logic                     pop,
  output wr_entry_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  wr_entry_t     store [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = store[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) store[wptr] <= push_data;
  end

endmodule

// File: rtl/powerup_sprite_sched.sv
// Powerup sprite memory controller: renderer read addressing, vblank-only write drain
// and the power-pellet blink timer (enabled by defining PWRUP_BLINK_EN).
module powerup_sprite_sched
  import powerup_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int BLINK_FRAMES = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               vblank,
  input  logic               rd_req,
  input  logic [3:0]         rd_x,
  input  logic [3:0]         rd_y,
  output logic               rd_valid,
  output pixel_t             rd_pixel,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  pixel_t             wr_data,
  output logic               wr_ready,
  output logic               visible,
  output logic [ADDR_W-1:0]  mem_read_address,
  output logic [ADDR_W-1:0]  mem_write_address,
  output pixel_t             mem_data_In,
  output logic               mem_we,
  input  pixel_t             mem_data_Out,
  output sched_state_t       dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t  state;
  sched_state_t  state_nx;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full_unused;
  logic [CW-1:0] fifo_count;
  wr_entry_t     head;
  logic          rd_oor;
  logic          rd_oor_q;

  assign dbg_state = state;

  // Read path: address is combinational, the memory registers its output, so the
  // valid and out-of-range flags travel one cycle alongside the request.
  assign mem_read_address = ADDR_W'(rd_y) * ADDR_W'(SPRITE_DIM) + ADDR_W'(rd_x);
  assign rd_oor = (rd_x > 4'(SPRITE_DIM - 1)) | (rd_y > 4'(SPRITE_DIM - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_valid <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_oor_q <= rd_oor;
    end
  end

  assign rd_pixel = (rd_valid & ~rd_oor_q & visible) ? mem_data_Out : '0;

  assign wr_ready = (fifo_count != CW'(FIFO_DEPTH));

  powerup_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (wr_req & wr_ready),
    .push_data ('{addr: wr_addr, data: wr_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Drain only while vblank holds; leftovers wait for the next blank.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (vblank && !fifo_empty) state_nx = DRAIN;
      end
      DRAIN: begin
        if (vblank && !fifo_empty) pop = 1'b1;
        else                       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_we            <= 1'b0;
      mem_write_address <= '0;
      mem_data_In       <= '0;
    end else begin
      mem_we <= pop & addr_in_range(head.addr);
      if (pop) begin
        mem_write_address <= head.addr;
        mem_data_In       <= head.data;
      end
    end
  end

`ifdef PWRUP_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign visible = 1'b1;
`endif

endmodule

// File: tb/tb_powerup_sprite_sched.sv
// Self-checking bench for powerup_sprite_sched with a behavioural sprite memory,
// table-driven read vectors, directed drain sequences and randomized write/read rounds.
module tb_powerup_sprite_sched;
  import powerup_pkg::*;

  localparam int FIFO_DEPTH   = 8;
  localparam int BLINK_FRAMES = 15;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         frame_start = 1'b0;
  logic         vblank = 1'b0;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_x = '0;
  logic [3:0]   rd_y = '0;
  logic         wr_req = 1'b0;
  logic [7:0]   wr_addr = '0;
  pixel_t       wr_data = '0;
  logic         rd_valid;
  pixel_t       rd_pixel;
  logic         wr_ready;
  logic         visible;
  logic [7:0]   mem_read_address;
  logic [7:0]   mem_write_address;
  pixel_t       mem_data_In;
  logic         mem_we;
  pixel_t       mem_data_Out;
  sched_state_t dbg_state;

  // Clock / reset
  always #5 Clk = ~Clk;

  powerup_sprite_sched #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .frame_start       (frame_start),
    .vblank            (vblank),
    .rd_req            (rd_req),
    .rd_x              (rd_x),
    .rd_y              (rd_y),
    .rd_valid          (rd_valid),
    .rd_pixel          (rd_pixel),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .visible           (visible),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_data_In       (mem_data_In),
    .mem_we            (mem_we),
    .mem_data_Out      (mem_data_Out),
    .dbg_state         (dbg_state)
  );

  // Sprite memory: registered read, write on we, read-before-write.
  pixel_t sprite_mem [256];
  pixel_t init_mem   [256];
  logic   mem_init = 1'b1;

  always @(posedge Clk) begin
    mem_data_Out <= sprite_mem[mem_read_address];
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sprite_mem[i] <= init_mem[i];
    end else if (mem_we) begin
      sprite_mem[mem_write_address] <= mem_data_In;
    end
  end

  // Reference model and scoreboard
  pixel_t     ref_mem [256];
  logic [9:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         commits = 0;
  int         frames = 0;
  logic       vis_m = 1'b1;
  logic       committed_now = 1'b0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] addr;
    logic       oor;
  } rd_vec_t;

  rd_vec_t rd_tab [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; commits are scored against the queued write order.
  task automatic tick();
    logic [9:0] e;
    @(posedge Clk);
    #1;
    committed_now = 1'b0;
    if (!Reset && mem_we) begin
      committed_now = 1'b1;
      commits++;
      while (exp_q.size() > 0 && exp_q[0][9:2] > 8'd224) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected: got addr %0d expected no write", mem_write_address);
      end else begin
        e = exp_q.pop_front();
        check("commit_addr", mem_write_address, e[9:2]);
        check("commit_data", mem_data_In, e[1:0]);
        ref_mem[e[9:2]] = e[1:0];
      end
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input pixel_t d);
    logic room;
    room = (exp_q.size() < FIFO_DEPTH);
    check("wr_ready_offer", wr_ready, room);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_req = 1'b0;
    if (room) exp_q.push_back({a, d});
  endtask

  task automatic do_read(input logic [3:0] x, input logic [3:0] y, input string tag);
    int     a;
    logic   oor;
    pixel_t exp_pix;
    a   = (int'(y) * 15 + int'(x)) % 256;
    oor = (x > 4'd14) || (y > 4'd14);
    rd_req = 1'b1;
    rd_x   = x;
    rd_y   = y;
    #1;
    check({tag, "_addr"}, mem_read_address, a);
    exp_pix = (oor || !vis_m) ? 2'd0 : ref_mem[a];
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_pixel"}, rd_pixel, exp_pix);
  endtask

  task automatic drain_all();
    int n;
    int leftover;
    n = exp_q.size() + 4;
    vblank = 1'b1;
    repeat (n) tick();
    vblank = 1'b0;
    repeat (2) tick();
    leftover = 0;
    foreach (exp_q[i]) if (exp_q[i][9:2] <= 8'd224) leftover++;
    check("drain_leftover", leftover, 0);
    exp_q.delete();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    frames++;
`ifdef PWRUP_BLINK_EN
    vis_m = ((frames / BLINK_FRAMES) % 2) == 0;
`else
    vis_m = 1'b1;
`endif
  endtask

  initial begin
    int c0;
    int first;
    int last;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) begin
      init_mem[i] = pixel_t'($urandom_range(0, 3));
      ref_mem[i]  = init_mem[i];
    end
    rd_tab[0] = '{x: 4'd3,  y: 4'd2,  addr: 8'd33,  oor: 1'b0};
    rd_tab[1] = '{x: 4'd15, y: 4'd0,  addr: 8'd15,  oor: 1'b1};
    rd_tab[2] = '{x: 4'd0,  y: 4'd0,  addr: 8'd0,   oor: 1'b0};
    rd_tab[3] = '{x: 4'd14, y: 4'd14, addr: 8'd224, oor: 1'b0};
    rd_tab[4] = '{x: 4'd0,  y: 4'd15, addr: 8'd225, oor: 1'b1};
    rd_tab[5] = '{x: 4'd14, y: 4'd0,  addr: 8'd14,  oor: 1'b0};
    rd_tab[6] = '{x: 4'd0,  y: 4'd14, addr: 8'd210, oor: 1'b0};
    rd_tab[7] = '{x: 4'd15, y: 4'd15, addr: 8'd240, oor: 1'b1};

    repeat (3) @(posedge Clk);
    #1;
    mem_init = 1'b0;
    Reset    = 1'b0;

    // Reset state
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_pixel", rd_pixel, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_waddr", mem_write_address, 0);
    check("rst_mem_din", mem_data_In, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_visible", visible, 1);
    check("rst_state", dbg_state, IDLE);

    // Table-driven reads
    for (int i = 0; i < 8; i++) begin
      check("tab_addr_formula", (int'(rd_tab[i].y) * 15 + int'(rd_tab[i].x)) % 256, rd_tab[i].addr);
      do_read(rd_tab[i].x, rd_tab[i].y, "tab_read");
      if (rd_tab[i].oor) check("tab_oor_pixel", rd_pixel, 0);
    end
    tick();
    check("rd_valid_drops", rd_valid, 0);

    // Fill the queue outside vblank, then one burst drain
    c0 = commits;
    for (int i = 0; i < 8; i++) push_wr(8'(i * 20 + 3), pixel_t'($urandom_range(0, 3)));
    check("full_wr_ready", wr_ready, 0);
    push_wr(8'd100, 2'd3);
    repeat (4) tick();
    check("no_commit_outside_vblank", commits - c0, 0);
    vblank = 1'b1;
    first  = -1;
    last   = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (committed_now) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    check("burst_commits", commits - c0, 8);
    check("burst_consecutive", last - first + 1, 8);
    check("burst_state", dbg_state, IDLE);
    check("burst_wr_ready", wr_ready, 1);
    vblank = 1'b0;
    tick();
    exp_q.delete();

    // vblank falls part-way through a drain
    c0 = commits;
    for (int i = 0; i < 5; i++) push_wr(8'(i * 7 + 150), pixel_t'($urandom_range(0, 3)));
    vblank = 1'b1;
    for (int cyc = 0; cyc < 20 && (commits - c0) < 3; cyc++) tick();
    if ((commits - c0) < 3) begin
      checks++;
      errors++;
      $display("FAIL partial_timeout: got %0d commits expected 3", commits - c0);
    end
    vblank = 1'b0;
    repeat (3) tick();
    check("partial_commits", commits - c0, 3);
    check("partial_remaining", exp_q.size(), 2);
    check("partial_state", dbg_state, IDLE);
    drain_all();
    check("partial_total", commits - c0, 5);

    // Out-of-range address is popped but not written
    c0 = commits;
    push_wr(8'd230, 2'd1);
    push_wr(8'd10, 2'd2);
    drain_all();
    check("drop_commits", commits - c0, 1);
    check("drop_wr_ready", wr_ready, 1);
    do_read(4'd10, 4'd0, "drop_read");

    // Randomized write rounds followed by random reads
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(225, 255)) : 8'($urandom_range(0, 224));
        push_wr(a, pixel_t'($urandom_range(0, 3)));
      end
      drain_all();
      for (int i = 0; i < 8; i++)
        do_read(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand_read");
    end

    // Blink timer
`ifdef PWRUP_BLINK_EN
    for (int f = 0; f < 2 * BLINK_FRAMES; f++) begin
      pulse_frame();
      repeat (2) tick();
      if (f == BLINK_FRAMES - 2 || f == BLINK_FRAMES - 1 || f == 2 * BLINK_FRAMES - 1)
        check("blink_visible", visible, vis_m);
      if (f == BLINK_FRAMES - 1) do_read(4'd3, 4'd2, "blink_hidden_read");
    end
    do_read(4'd3, 4'd2, "blink_shown_read");
`else
    for (int f = 0; f < 100; f++) begin
      pulse_frame();
      if (f % 25 == 24) check("noblink_visible", visible, 1);
    end
    do_read(4'd3, 4'd2, "noblink_read");
`endif

    // Reset in the middle of a drain discards the queue
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom_range(0, 224));
      push_wr(a, ref_mem[a]);
    end
    c0 = commits;
    vblank = 1'b1;
    for (int cyc = 0; cyc < 20 && (commits - c0) < 2; cyc++) tick();
    Reset = 1'b1;
    #2;
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_visible", visible, 1);
    exp_q.delete();
    frames = 0;
    vis_m  = 1'b1;
    #2;
    Reset = 1'b0;
    c0 = commits;
    repeat (6) tick();
    check("midrst_no_commit", commits - c0, 0);
    check("midrst_state_after", dbg_state, IDLE);
    vblank = 1'b0;
    do_read(4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)), "midrst_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
